// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dm_arb_pkg
// Brief   : Shared types and constants for the data-RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

   // Owner of the RAM port in a given cycle
   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_CPU  = 2'b01,
      GNT_AUX  = 2'b10
   } grant_e;

   // Width of the aux starvation counter (MAX_WAIT is limited to 1..15)
   localparam int WAIT_W = 4;

endpackage : dm_arb_pkg
`default_nettype wire

// File: rtl/dm_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that saturates at LIMIT, with a synchronous clear that
//           takes precedence over increment.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] LIMIT = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] r_cnt;

   // Count up on inc, hold at LIMIT, clear on clr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dm_arbiter
// Brief   : Shares the single data-RAM port between the CPU (fixed priority)
//           and an auxiliary master, with a forced aux grant after MAX_WAIT
//           denied cycles. Zero-latency grant and data muxing.
// Revision: 1.0 - initial release
// ============================================================================
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   // CPU side
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   // Auxiliary master side
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_ack,
   output logic [DATA_W-1:0] aux_rdata,
   // RAM port
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   // Status
   output logic [1:0]        last_grant,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);

   grant_e            w_gnt;
   grant_e            r_last_grant;
   logic [WAIT_W-1:0] w_wait_cnt;
   logic              w_cpu_gnt;
   logic              w_aux_gnt;

   // Grant decision; nothing is granted while reset is held low
   always_comb begin
      w_gnt = GNT_NONE;
      if (rst) begin
         if (aux_req && (w_wait_cnt == c_max_wait)) begin
            w_gnt = GNT_AUX;
         end else if (cpu_req) begin
            w_gnt = GNT_CPU;
         end else if (aux_req) begin
            w_gnt = GNT_AUX;
         end
      end
   end

   assign w_cpu_gnt = (w_gnt == GNT_CPU);
   assign w_aux_gnt = (w_gnt == GNT_AUX);

   assign cpu_ack   = w_cpu_gnt;
   assign aux_ack   = w_aux_gnt;
   assign cpu_stall = cpu_req & ~w_cpu_gnt;

   // RAM-side mux and read-data steering; idle cycles drive zeros
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      cpu_rdata = '0;
      aux_rdata = '0;
      if (w_cpu_gnt) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we    = cpu_we;
         cpu_rdata = ram_rdata;
      end else if (w_aux_gnt) begin
         ram_addr  = aux_addr;
         ram_wdata = aux_wdata;
         ram_we    = aux_we;
         aux_rdata = ram_rdata;
      end
   end

   // Aux starvation counter: counts denied aux cycles, cleared once aux is
   // served or withdraws its request
   sat_counter #(
      .WIDTH (WAIT_W),
      .LIMIT (c_max_wait)
   ) u_wait_cnt (
      .clk (clk),
      .rst (rst),
      .inc (aux_req & ~w_aux_gnt),
      .clr (~aux_req | w_aux_gnt),
      .cnt (w_wait_cnt)
   );

   // Statistics: cycles with both masters requesting, saturating at all-ones
   sat_counter #(
      .WIDTH (CNT_W),
      .LIMIT ({CNT_W{1'b1}})
   ) u_conflict_cnt (
      .clk (clk),
      .rst (rst),
      .inc (cpu_req & aux_req),
      .clr (1'b0),
      .cnt (conflict_cnt)
   );

   // Remember who owned the port in the previous cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= GNT_NONE;
      end else begin
         r_last_grant <= w_gnt;
      end
   end

   assign last_grant = r_last_grant;

endmodule : dm_arbiter
`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter that shares the single data-RAM port between the CPU data path and an auxiliary master, such as the message-output streamer that drains decoded characters. The CPU has fixed priority. A saturating starvation counter forces one grant to the auxiliary master after a bounded wait. The block sits between the CPU/chipset data side and the `Ram` instance and drives the RAM address, write-data and write-enable.

## Interface
Parameters:
- `ADDR_W`, 10, RAM word-address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, aux cycles denied before a forced aux grant (range 1..15)
- `CNT_W`, 16, width of the conflict statistics counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU requests RAM this cycle
- `cpu_we`  in  1  CPU access is a write
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_ack`  out  1  CPU granted this cycle
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`
- `cpu_rdata`  out  DATA_W  read data to the CPU
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_ack`, `aux_rdata`: same as the CPU set, for the auxiliary master
- `ram_addr`  out  ADDR_W  to RAM
- `ram_wdata`  out  DATA_W  to RAM
- `ram_we`  out  1  RAM write enable
- `ram_rdata`  in  DATA_W  RAM combinational read data
- `last_grant`  out  2  registered owner of the previous cycle
- `conflict_cnt`  out  CNT_W  cycles in which both requests were high

## Operation
- Each cycle the arbiter grants at most one requester.
- Grant decision is combinational from `cpu_req`, `aux_req` and the registered `wait_cnt`:
  - If `aux_req` and `wait_cnt == MAX_WAIT`: grant AUX (forced).
  - Else if `cpu_req`: grant CPU.
  - Else if `aux_req`: grant AUX.
  - Else: NONE.
- Data path:
  - Granted master's address and write-data are muxed to `ram_addr` and `ram_wdata`.
  - `ram_we = ack & we` of the granted master.
  - With no grant: `ram_addr`, `ram_wdata` and `ram_we` are all 0.
- Read data: `ram_rdata` goes to the granted master's `*_rdata`. The non-granted master's `*_rdata` is 0.
- `wait_cnt` (registered, 4 bits):
  - Increments when `aux_req` is high and AUX is not granted; saturates at `MAX_WAIT`.
  - Clears to 0 on an AUX grant or when `aux_req` is low.
- `last_grant` registers the grant encoding every cycle.
- `conflict_cnt` increments when `cpu_req & aux_req`, saturating at all-ones.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until they see `ack`. A request may be dropped before `ack`; no state is retained except `wait_cnt` clearing.

## Timing
- Grant, ack, RAM muxing and rdata are zero-latency: same cycle as the request.
- A write commits at the rising edge that ends the ack cycle. A read is valid during the ack cycle.
- Worst-case aux latency is `MAX_WAIT + 1` cycles from the first request cycle. With `MAX_WAIT = 4`, ack arrives in the 5th cycle.
- Forced aux cycle: the CPU sees `cpu_stall = 1` for exactly one cycle, then regains priority because `wait_cnt` returns to 0.
- Simultaneous requests in the same cycle resolve per the priority order above; there is never a double ack.
- Reset (`rst` low, asynchronous):
  - `wait_cnt = 0`, `last_grant = GNT_NONE`, `conflict_cnt = 0`.
  - Both acks, `ram_we`, `ram_addr`, `ram_wdata` and both rdata outputs are forced to 0 while `rst` is low, regardless of requests.
  - A transaction in flight during reset is dropped and no write occurs.
- Deassertion of `rst` takes effect at the next rising edge; normal arbitration starts that cycle.

## Structure
- Package `dm_arb_pkg`:
  - Enum `grant_e`: `GNT_NONE = 2'b00`, `GNT_CPU = 2'b01`, `GNT_AUX = 2'b10`.
  - Localparam `WAIT_W = 4`.
- Sub-module `sat_counter` (parameterised width and limit; inputs `inc` and synchronous `clr`; async active-low reset). It is instantiated twice: once for `wait_cnt` and once for `conflict_cnt`.
- The remainder of the block is the grant logic, the output muxes and the `last_grant` register.

## Test plan
All scenarios use `MAX_WAIT = 4`.
- Reset: hold `rst = 0` with both requests high -> all acks 0, `ram_we = 0`, `last_grant = 00`, `conflict_cnt = 0`.
- CPU only: write `0x41` to address `0x010`, then read `0x010` -> `cpu_ack = 1` both cycles, `cpu_rdata = 0x41`, `conflict_cnt` unchanged.
- Contention: CPU and aux requesting continuously -> CPU acked cycles 1–4, aux acked in cycle 5, `cpu_stall` high only in cycle 5, CPU acked again from cycle 6, `conflict_cnt = 5` after 5 cycles.
- Aux alone: aux reads address `0x3FF` with `cpu_req = 0` -> same-cycle `aux_ack`, `last_grant = 10` next cycle.
- Aux drop: aux waits 2 cycles then deasserts `aux_req` -> `wait_cnt` returns to 0; a new contention run again needs 4 denied cycles before the forced grant.
- Reset mid-write: assert `rst = 0` during a CPU write cycle before the clock edge -> no RAM write; memory keeps its old value and counters are cleared.
